// File: rtl/alu_mc_pkg.sv
// alu_mc shared types: op encodings, FSM states and op classification.
// Optional flag outputs are enabled by ALU_MC_FLAGS_EN.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_NOR  = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_MUL  = 4'b1011,
    ALU_DIVU = 4'b1100
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

  localparam logic [3:0] OP_MUL  = ALU_MUL;
  localparam logic [3:0] OP_DIVU = ALU_DIVU;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply, restoring divide.
// hi/lo hold acc/multiplier (mul) or remainder/quotient (divu).
module alu_mc_iter import alu_mc_pkg::*; #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         div_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] lo_o,
  output logic [N-1:0] hi_o
);

  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N:0]    sum;
  logic [N:0]    rsh;
  logic [N:0]    dif;
  logic          dz;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    m_d   = m_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rsh   = {hi_q, lo_q[N-1]};
    dif   = rsh - {1'b0, m_q};
    // divide by zero must keep every quotient bit set
    dz    = (m_q == '0);
    if (start_i) begin
      cnt_d = CW'(N);
      div_d = div_i;
      m_d   = div_i ? b_i : a_i;
      hi_d  = '0;
      lo_d  = div_i ? a_i : b_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        if (!dif[N] || dz) begin
          hi_d = dif[N-1:0];
          lo_d = {lo_q[N-2:0], 1'b1};
        end else begin
          hi_d = rsh[N-1:0];
          lo_d = {lo_q[N-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {sum, lo_q[N-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      m_q   <= m_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // final iteration's values are handed over as the counter hits zero
  assign done_o = (cnt_q == CW'(1));
  assign lo_o   = lo_d;
  assign hi_o   = hi_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes.
// Define ALU_MC_FLAGS_EN to add registered ovf/neg outputs.
module alu_mc import alu_mc_pkg::*; #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [N-1:0] y_hi,
  output logic         zero
`ifdef ALU_MC_FLAGS_EN
  ,
  output logic         ovf,
  output logic         neg
`endif
);

  localparam int SHW = $clog2(N);

  alu_state_t   state_q, state_d;
  logic [N-1:0] y_q, y_d;
  logic [N-1:0] yhi_q, yhi_d;
  logic         zero_q, zero_d;
  logic [N-1:0] res;
  logic [N-1:0] sum;
  logic [N-1:0] dif;
  logic [SHW-1:0] sh;
  logic         start;
  logic         it_done;
  logic [N-1:0] it_lo;
  logic [N-1:0] it_hi;

  assign sum = a + b;
  assign dif = a - b;
  assign sh  = b[SHW-1:0];

  always_comb begin
    res = '0;
    unique case (op)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = sum;
      ALU_NOR:  res = ~(a | b);
      ALU_SUB:  res = dif;
      ALU_SLT:  res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL:  res = a << sh;
      ALU_SRL:  res = a >> sh;
      ALU_SRA:  res = $unsigned($signed(a) >>> sh);
      ALU_SLTU: res = {{(N-1){1'b0}}, a < b};
      ALU_XOR:  res = a ^ b;
      default:  res = '0;
    endcase
  end

`ifdef ALU_MC_FLAGS_EN
  logic ovf_q, ovf_d;
  logic neg_q, neg_d;
  logic ovf_c;

  always_comb begin
    ovf_c = 1'b0;
    if (op == ALU_ADD)
      ovf_c = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    else if (op == ALU_SUB)
      ovf_c = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
  end
`endif

  alu_mc_iter #(.N(N)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .div_i   (op == OP_DIVU),
    .a_i     (a),
    .b_i     (b),
    .done_o  (it_done),
    .lo_o    (it_lo),
    .hi_o    (it_hi)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    yhi_d   = yhi_q;
    zero_d  = zero_q;
    start   = 1'b0;
`ifdef ALU_MC_FLAGS_EN
    ovf_d   = ovf_q;
    neg_d   = neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_multicycle(op)) begin
            start   = 1'b1;
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            y_d     = res;
            yhi_d   = '0;
            zero_d  = (res == '0);
`ifdef ALU_MC_FLAGS_EN
            ovf_d   = ovf_c;
            neg_d   = res[N-1];
`endif
          end
        end
      end
      S_BUSY: begin
        if (it_done) begin
          state_d = S_DONE;
          y_d     = it_lo;
          yhi_d   = it_hi;
          zero_d  = (it_lo == '0);
`ifdef ALU_MC_FLAGS_EN
          ovf_d   = 1'b0;
          neg_d   = it_lo[N-1];
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      yhi_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      yhi_q   <= yhi_d;
      zero_q  <= zero_d;
    end
  end

`ifdef ALU_MC_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      neg_q <= neg_d;
    end
  end

  assign ovf = ovf_q;
  assign neg = neg_q;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign y_hi      = yhi_q;
  assign zero      = zero_q & out_valid;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (N = 32).
// Flag checks run only when ALU_MC_FLAGS_EN is defined.
module tb_alu_mc;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic [N-1:0] y_hi;
  logic         zero;
`ifdef ALU_MC_FLAGS_EN
  logic         ovf;
  logic         neg;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_mc #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_hi      (y_hi),
    .zero      (zero)
`ifdef ALU_MC_FLAGS_EN
    ,
    .ovf       (ovf),
    .neg       (neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one op, wait for its result, then pop it
  task automatic do_op(input logic [3:0] o, input logic [N-1:0] av,
                       input logic [N-1:0] bv,
                       output logic [N-1:0] ry, output logic [N-1:0] rh,
                       output logic rz, output int lat,
                       output logic rdy_seen);
    a = av;
    b = bv;
    op = o;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = in_ready;
    while (!out_valid && lat < 200) begin
      cyc();
      lat++;
      rdy_seen = rdy_seen | in_ready;
    end
    ry = y;
    rh = y_hi;
    rz = zero;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  logic [N-1:0] ry, rh, hold;
  logic         rz, rdy;
  int           lat;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_y_hi", y_hi, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    cyc();
    chk("rst_in_ready", in_ready, 1);

    // 1: add handshake
    a = 5;
    b = 7;
    op = 4'b0010;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("add_out_valid", out_valid, 1);
    chk("add_y", y, 12);
    chk("add_zero", zero, 0);
    chk("add_in_ready", in_ready, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("add_pop_in_ready", in_ready, 1);
    chk("add_pop_out_valid", out_valid, 0);

    // 2: compares, shifts and other single-cycle ops
    do_op(4'b0101, 32'hFFFF_FFFF, 32'd1, ry, rh, rz, lat, rdy);
    chk("slt_y", ry, 1);
    chk("slt_lat", lat, 1);
    do_op(4'b1001, 32'hFFFF_FFFF, 32'd1, ry, rh, rz, lat, rdy);
    chk("sltu_y", ry, 0);
    chk("sltu_zero", rz, 1);
    do_op(4'b1000, 32'h8000_0000, 32'd4, ry, rh, rz, lat, rdy);
    chk("sra_y", ry, 32'hF800_0000);
    do_op(4'b0111, 32'h8000_0000, 32'd4, ry, rh, rz, lat, rdy);
    chk("srl_y", ry, 32'h0800_0000);
    do_op(4'b0110, 32'd1, 32'd35, ry, rh, rz, lat, rdy);
    chk("sll_wrap_amt", ry, 8);
    do_op(4'b0110, 32'd1, 32'd31, ry, rh, rz, lat, rdy);
    chk("sll_31", ry, 32'h8000_0000);
    do_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, ry, rh, rz, lat, rdy);
    chk("and_y", ry, 32'h00F0_1200);
    do_op(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, ry, rh, rz, lat, rdy);
    chk("or_y", ry, 32'hFFF0_FF34);
    do_op(4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, ry, rh, rz, lat, rdy);
    chk("nor_y", ry, 32'h000F_00CB);
    do_op(4'b0100, 32'd5, 32'd7, ry, rh, rz, lat, rdy);
    chk("sub_y", ry, 32'hFFFF_FFFE);
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, ry, rh, rz, lat, rdy);
    chk("add_wrap_y", ry, 0);
    chk("add_wrap_zero", rz, 1);
    do_op(4'b1010, 32'hFF00_FF00, 32'h0F0F_0F0F, ry, rh, rz, lat, rdy);
    chk("xor_y", ry, 32'hF00F_F00F);
    do_op(4'b1101, 32'h1234_5678, 32'h1, ry, rh, rz, lat, rdy);
    chk("rsvd_y", ry, 0);
    chk("rsvd_y_hi", rh, 0);
    chk("rsvd_lat", lat, 1);

    // 3: multiply
    do_op(4'b1011, 32'h0001_0000, 32'h0001_0000, ry, rh, rz, lat, rdy);
    chk("mul_lat", lat, 33);
    chk("mul_y", ry, 0);
    chk("mul_y_hi", rh, 1);
    chk("mul_zero", rz, 1);
    chk("mul_in_ready_busy", rdy, 0);
    do_op(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ry, rh, rz, lat, rdy);
    chk("mul_max_y", ry, 1);
    chk("mul_max_y_hi", rh, 32'hFFFF_FFFE);

    // 4: divide
    do_op(4'b1100, 32'd100, 32'd7, ry, rh, rz, lat, rdy);
    chk("divu_lat", lat, 33);
    chk("divu_y", ry, 14);
    chk("divu_y_hi", rh, 2);
    do_op(4'b1100, 32'd9, 32'd0, ry, rh, rz, lat, rdy);
    chk("div0_y", ry, 32'hFFFF_FFFF);
    chk("div0_y_hi", rh, 9);
    chk("div0_lat", lat, 33);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'd0, ry, rh, rz, lat, rdy);
    chk("div0_big_y", ry, 32'hFFFF_FFFF);
    chk("div0_big_y_hi", rh, 32'hFFFF_FFFF);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'd10, ry, rh, rz, lat, rdy);
    chk("divu_big_y", ry, 32'h1999_9999);
    chk("divu_big_y_hi", rh, 5);

    // 5a: backpressure on an xor result
    a = 32'h1234_5678;
    b = 32'hFFFF_0000;
    op = 4'b1010;
    in_valid = 1'b1;
    cyc();
    hold = 32'hEDCB_5678;
    chk("bp_y0", y, hold);
    for (int i = 0; i < 5; i++) begin
      a = 32'h1111_1111 * (i + 1);
      b = 32'h0F0F_0F0F + i;
      op = 4'b0010;
      in_valid = 1'b1;
      cyc();
      chk("bp_y_stable", y, hold);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_pop_out_valid", out_valid, 0);
    chk("bp_pop_in_ready", in_ready, 1);

    // 5b: async reset in the middle of a multiply
    a = 32'd3;
    b = 32'd3;
    op = 4'b1011;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("mid_busy_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_y", y, 0);
    chk("arst_in_ready", in_ready, 1);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) cyc();
    chk("arst_no_stale", out_valid, 0);
    do_op(4'b0010, 32'd2, 32'd3, ry, rh, rz, lat, rdy);
    chk("post_rst_y", ry, 5);
    chk("post_rst_lat", lat, 1);
    do_op(4'b1011, 32'd6, 32'd7, ry, rh, rz, lat, rdy);
    chk("post_rst_mul_y", ry, 42);
    chk("post_rst_mul_lat", lat, 33);

`ifdef ALU_MC_FLAGS_EN
    // 6: flags
    a = 32'h7FFF_FFFF;
    b = 32'd1;
    op = 4'b0010;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("flg_add_y", y, 32'h8000_0000);
    chk("flg_add_ovf", ovf, 1);
    chk("flg_add_neg", neg, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    a = 32'd3;
    b = 32'd5;
    op = 4'b0100;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("flg_sub_ovf", ovf, 0);
    chk("flg_sub_neg", neg, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
